mc_datapath: RTL and testbench
==============================

# mc_datapath

Parametrised multi-cycle successor to the single-cycle integer datapath: executes the same 32-bit ISA (ADD, AND, MOV, LD, ST, BR, JMP, JSR, JSRR) with a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data memories are external, behind req/ready handshakes, so wait-state memories can be attached. Adds asynchronous reset, signed condition codes, an illegal-opcode trap and a retire pulse for the simulator trace.

## Interface
- DW, 16: integer register and data width (≥16).
- NREG, 16: integer register count (≤16; register fields are 4 bits).
- PC_W, 16: PC / instruction byte-address width.
- DA_W, 16: data word-address width.
- RESET_PC, 0: PC value after reset.
- RET_REG, 7: link register index for JSR/JSRR.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- lock  in  1  run enable; sampled only in FETCH.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  byte address (= PC).
- imem_rdata  in  32  instruction word.
- imem_ready  in  1  fetch completes in a cycle where req & ready.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DA_W  word address.
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data.
- dmem_ready  in  1  access completes in a cycle where req & ready.
- pc  out  PC_W  architectural PC.
- cc  out  3  condition code {P,Z,N}.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky; set on illegal instruction.

## Operation
- Fields: opcode IR[31:27], format/cond IR[26:24], dst IR[23:20], src1 IR[19:16], src2 IR[11:8], imm IR[15:0]. Opcode/format encodings come from the shared definitions header (OP_*, FORMAT_*).
- Register indices ≥ NREG, or an unknown opcode/format, → TRAP.
- imm is sign-extended to DW. Higher bits are truncated when widths shrink.
- States:
  - FETCH: imem_req = lock. On req & ready, IR ← imem_rdata → DECODE.
  - DECODE: read src1, src2 and REG[dst] (store data) → EXEC.
  - EXEC: ALU / address / branch evaluation. LD/ST → MEM, legal others → WB, illegal → TRAP.
  - MEM: dmem_req held until ready. LD captures dmem_rdata → WB.
  - WB: register write, CC update, PC update, retire = 1 → FETCH.
  - TRAP: halted = 1, all requests low. Exited only by reset.
- ADD/AND: IR format src1 op src2; II format src1 op sext(imm). Result → REG[dst]; sets CC.
- MOV: src2 or sext(imm) → REG[src1 field]; sets CC.
- LD (FORMAT_LDST_W): REG[dst] ← mem[src1+sext(imm)]; sets CC.
- ST (FORMAT_LDST_W): mem[src1+sext(imm)] ← REG[dst]; CC unchanged.
- CC is a signed compare with 0: N = 001 if result[DW-1], Z = 010 if result is 0, else P = 100.
- BR: taken iff (IR[26]&N)|(IR[25]&Z)|(IR[24]&P). Target = PC + (sext(imm)<<2).
- JMP: PC ← src1.
- JSR: REG[RET_REG] ← PC+4, PC ← PC + (sext(imm)<<2).
- JSRR: REG[RET_REG] ← PC+4, PC ← src1. If src1 = RET_REG, the old value read in DECODE is used.
- Not-taken branches and all other instructions: PC ← PC+4.
- All PC arithmetic wraps mod 2^PC_W.

## Timing
- Reset (async assert) → FETCH, PC = RESET_PC, all registers 0, cc = 010, IR = 0.
  - All outputs low except pc and cc.
  - Any outstanding request drops immediately; an in-flight store is abandoned.
- Deassertion of rst_n takes effect at the next rising edge.
- Zero-wait memory latency: 4 cycles for ALU, MOV, BR, JMP, JSR, JSRR; 5 cycles for LD/ST. Each wait cycle adds 1.
- Handshake: req, address and wdata stay stable until the ready cycle. Ready while req is low is ignored. req drops the cycle after completion.
- lock = 0 in FETCH: no request is issued and the state holds. Once a fetch is accepted, the instruction completes regardless of lock.
- REG, PC and cc update at the WB edge; the next FETCH uses the new PC.

## Test plan
- Reset, lock = 1, zero-wait memories, MOV R1,#5; ADD R2,R1,#-6 → R1 = 5 (cc = 100), R2 = 0xFFFF (cc = 001), retire every 4 cycles, pc = 8.
- ST R2→[R0+3] then LD R3,[R0+3] with dmem_ready delayed 3 cycles → dmem_addr = 3, wdata = 0xFFFF, R3 = 0xFFFF, each access 8 cycles.
- cc = Z, BR z #-2 at pc 0x10 → pc = 0x08. BR p at the same point → pc = 0x14.
- JSR #4 at pc 0x20 → R7 = 0x24, pc = 0x30. JSRR R7 → pc = 0x24, R7 = 0x34.
- Illegal opcode → halted = 1 after EXEC, no further requests. rst_n pulsed low mid-MEM → dmem_req drops asynchronously, pc = RESET_PC.
- lock low for 10 cycles in FETCH → imem_req stays 0 and pc is unchanged; on raise, the fetch resumes at the same pc.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle FETCH/DECODE/EXEC/MEM/WB integer datapath with handshaked memories
module mc_datapath #(
  parameter int DW = 16,
  parameter int NREG = 16,
  parameter int PC_W = 16,
  parameter int DA_W = 16,
  parameter int RESET_PC = 0,
  parameter int RET_REG = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lock,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [DA_W-1:0] dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_ready,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      cc,
  output logic            retire,
  output logic            halted
);
  localparam logic [4:0] OP_ADD = 5'd1, OP_AND = 5'd2, OP_MOV = 5'd3, OP_LD = 5'd4, OP_ST = 5'd5;
  localparam logic [4:0] OP_BR = 5'd6, OP_JMP = 5'd7, OP_JSR = 5'd8, OP_JSRR = 5'd9;
  localparam logic [2:0] FORMAT_IR = 3'd0, FORMAT_II = 3'd1, FORMAT_LDST_W = 3'd2;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state;
  logic [31:0] ir;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] a, b, s, res, imm_x, opb, nres;
  logic [PC_W-1:0] npc, nnpc, pc4, br_off;
  logic [DA_W-1:0] maddr, naddr;
  logic [3:0] widx, nidx;
  logic wr, wcc, ld, nwr, nwcc, nld, nst, legal, fmt_ok, ok_rd, ok_rs1, ok_rs2, taken;
  logic [4:0] op;
  logic [2:0] fmt;
  logic [3:0] rd, rs1, rs2;
  assign op = ir[31:27];
  assign fmt = ir[26:24];
  assign rd = ir[23:20];
  assign rs1 = ir[19:16];
  assign rs2 = ir[11:8];
  assign imm_x = DW'({{DW{ir[15]}}, ir[15:0]});
  assign br_off = PC_W'({{PC_W{ir[15]}}, ir[15:0], 2'b00});
  assign pc4 = pc + PC_W'(4);
  assign opb = fmt == FORMAT_II ? imm_x : b;
  assign fmt_ok = fmt == FORMAT_IR || fmt == FORMAT_II;
  assign ok_rd = int'(rd) < NREG;
  assign ok_rs1 = int'(rs1) < NREG;
  assign ok_rs2 = fmt == FORMAT_II || int'(rs2) < NREG;
  assign taken = (ir[26] & cc[0]) | (ir[25] & cc[1]) | (ir[24] & cc[2]);
  assign imem_req = rst_n && lock && state == FETCH;
  assign imem_addr = pc;
  assign dmem_addr = maddr;
  assign dmem_wdata = s;
  function automatic logic [DW-1:0] rdr(input logic [3:0] i);
    return int'(i) < NREG ? regs[i] : '0;
  endfunction
  function automatic logic [2:0] ccf(input logic [DW-1:0] v);
    return v[DW-1] ? 3'b001 : v == '0 ? 3'b010 : 3'b100;
  endfunction
  // execute-stage decode: result, next PC, write-back target and legality
  always_comb begin
    legal = 1'b0;
    nres = '0;
    nnpc = pc4;
    nwr = 1'b0;
    nwcc = 1'b0;
    nidx = rd;
    nld = 1'b0;
    nst = 1'b0;
    naddr = DA_W'(a + imm_x);
    case (op)
      OP_ADD, OP_AND: begin
        nres = op == OP_ADD ? a + opb : a & opb;
        nwr = 1'b1;
        nwcc = 1'b1;
        legal = fmt_ok && ok_rd && ok_rs1 && ok_rs2;
      end
      OP_MOV: begin
        nres = opb;
        nidx = rs1;
        nwr = 1'b1;
        nwcc = 1'b1;
        legal = fmt_ok && ok_rs1 && ok_rs2;
      end
      OP_LD: begin
        nld = 1'b1;
        nwr = 1'b1;
        nwcc = 1'b1;
        legal = fmt == FORMAT_LDST_W && ok_rd && ok_rs1;
      end
      OP_ST: begin
        nst = 1'b1;
        legal = fmt == FORMAT_LDST_W && ok_rd && ok_rs1;
      end
      OP_BR: begin
        nnpc = taken ? pc + br_off : pc4;
        legal = 1'b1;
      end
      OP_JMP: begin
        nnpc = PC_W'(a);
        legal = ok_rs1;
      end
      OP_JSR, OP_JSRR: begin
        nres = DW'(pc4);
        nidx = 4'(RET_REG);
        nwr = 1'b1;
        nnpc = op == OP_JSR ? pc + br_off : PC_W'(a);
        legal = op == OP_JSR || ok_rs1;
      end
      default: ;
    endcase
  end
  // multi-cycle state machine with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      ir <= '0;
      pc <= PC_W'(RESET_PC);
      cc <= 3'b010;
      a <= '0;
      b <= '0;
      s <= '0;
      res <= '0;
      npc <= '0;
      maddr <= '0;
      widx <= '0;
      wr <= 1'b0;
      wcc <= 1'b0;
      ld <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      retire <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (lock && imem_ready) begin
          ir <= imem_rdata;
          state <= DECODE;
        end
        DECODE: begin
          a <= rdr(rs1);
          b <= rdr(rs2);
          s <= rdr(rd);
          state <= EXEC;
        end
        EXEC: if (!legal) begin
          halted <= 1'b1;
          state <= TRAP;
        end else begin
          res <= nres;
          npc <= nnpc;
          maddr <= naddr;
          widx <= nidx;
          wr <= nwr;
          wcc <= nwcc;
          ld <= nld;
          dmem_req <= nld || nst;
          dmem_we <= nst;
          retire <= !(nld || nst);
          state <= nld || nst ? MEM : WB;
        end
        MEM: if (dmem_ready) begin
          if (ld) res <= dmem_rdata;
          dmem_req <= 1'b0;
          dmem_we <= 1'b0;
          retire <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (wr) regs[widx] <= res;
          if (wcc) cc <= ccf(res);
          pc <= npc;
          retire <= 1'b0;
          state <= FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed and randomized checks of mc_datapath against an ISA-level model
module tb_mc_datapath;
  localparam logic [4:0] OP_ADD = 5'd1, OP_AND = 5'd2, OP_MOV = 5'd3, OP_LD = 5'd4, OP_ST = 5'd5;
  localparam logic [4:0] OP_BR = 5'd6, OP_JMP = 5'd7, OP_JSR = 5'd8, OP_JSRR = 5'd9;
  localparam logic [2:0] F_IR = 3'd0, F_II = 3'd1, F_LDST = 3'd2;

  logic clk = 1'b0, rst_n = 1'b1, lock = 1'b1;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [15:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [31:0] imem_rdata;
  logic [2:0] cc;
  logic [31:0] imem [16384];
  logic [15:0] dmem [65536];
  logic [15:0] m_mem [65536];
  logic [15:0] m_reg [16];
  logic [15:0] m_pc;
  logic [2:0] m_cc;
  logic [15:0] last_addr, last_wdata, h_addr, h_wd, h_iaddr;
  logic last_we, hold_d, hold_i;
  int iwait = 0, dwait = 0, icnt, dcnt, stab_err = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk(clk), .rst_n(rst_n), .lock(lock),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .cc(cc), .retire(retire), .halted(halted)
  );

  assign imem_rdata = imem[imem_addr[15:2]];
  assign imem_ready = imem_req && icnt >= iwait;
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ready = dmem_req && dcnt >= dwait;

  // wait-state counters for both memories
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= imem_req && !imem_ready ? icnt + 1 : 0;
      dcnt <= dmem_req && !dmem_ready ? dcnt + 1 : 0;
    end
  end

  // data memory write port and last-transaction capture
  always @(posedge clk) begin
    if (rst_n && dmem_req && dmem_ready) begin
      if (dmem_we) dmem[dmem_addr] = dmem_wdata;
      last_addr = dmem_addr;
      last_wdata = dmem_wdata;
      last_we = dmem_we;
    end
  end

  // request payload must hold steady while a request waits for ready
  always @(posedge clk) begin
    hold_d <= dmem_req && !dmem_ready;
    hold_i <= imem_req && !imem_ready;
    h_addr <= dmem_addr;
    h_wd <= dmem_wdata;
    h_iaddr <= imem_addr;
  end
  always @(negedge clk) begin
    if ((hold_d && dmem_req && (dmem_addr != h_addr || dmem_wdata != h_wd)) ||
        (hold_i && imem_req && imem_addr != h_iaddr)) stab_err++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ei(input logic [4:0] op, input logic [2:0] f, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [15:0] imm);
    return {op, f, d, s1, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] op, input logic [3:0] d, input logic [3:0] s1,
                                     input logic [3:0] s2);
    return {op, F_IR, d, s1, 4'b0, s2, 8'b0};
  endfunction

  function automatic logic [2:0] ccof(input logic [15:0] v);
    return v[15] ? 3'b001 : v == 16'd0 ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'd0;
    m_pc = 16'd0;
    m_cc = 3'b010;
  endtask

  // one architectural instruction: updates model state, returns expected cycle count
  task automatic model_step(input logic [31:0] w, output int lat, output bit bad);
    logic [4:0] op;
    logic [2:0] f;
    logic [15:0] imm, opb, v, ea, nxt, pc4;
    int d, s1, s2;
    op = w[31:27];
    f = w[26:24];
    d = int'(w[23:20]);
    s1 = int'(w[19:16]);
    s2 = int'(w[11:8]);
    imm = w[15:0];
    opb = f == F_II ? imm : m_reg[s2];
    ea = m_reg[s1] + imm;
    pc4 = m_pc + 16'd4;
    nxt = pc4;
    bad = 0;
    lat = 4 + iwait;
    case (op)
      OP_ADD, OP_AND, OP_MOV: begin
        if (f != F_IR && f != F_II) bad = 1;
        else begin
          v = op == OP_ADD ? m_reg[s1] + opb : op == OP_AND ? m_reg[s1] & opb : opb;
          if (op == OP_MOV) m_reg[s1] = v;
          else m_reg[d] = v;
          m_cc = ccof(v);
        end
      end
      OP_LD, OP_ST: begin
        if (f != F_LDST) bad = 1;
        else begin
          lat += 1 + dwait;
          if (op == OP_ST) m_mem[ea] = m_reg[d];
          else begin
            m_reg[d] = m_mem[ea];
            m_cc = ccof(m_reg[d]);
          end
        end
      end
      OP_BR: if ((f[2] & m_cc[0]) | (f[1] & m_cc[1]) | (f[0] & m_cc[2])) nxt = m_pc + {imm[13:0], 2'b00};
      OP_JMP: nxt = m_reg[s1];
      OP_JSR: begin
        nxt = m_pc + {imm[13:0], 2'b00};
        m_reg[7] = pc4;
      end
      OP_JSRR: begin
        nxt = m_reg[s1];
        m_reg[7] = pc4;
      end
      default: bad = 1;
    endcase
    if (!bad) m_pc = nxt;
  endtask

  task automatic check_arch();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("cc", 32'(cc), 32'(m_cc));
    for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), 32'(dut.regs[i]), 32'(m_reg[i]));
  endtask

  // place an instruction at the model PC, run it, and compare latency and architectural state
  task automatic issue(input logic [31:0] w, input int iw, input int dw, input bit chk_lat);
    int lat, n;
    bit bad;
    iwait = iw;
    dwait = dw;
    imem[m_pc[15:2]] = w;
    model_step(w, lat, bad);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && !halted && n < 200);
    if (bad) begin
      chk("halted", 32'(halted), 32'd1);
      chk("trap_cycles", 32'(n), 32'(lat));
    end else begin
      chk("retire", 32'(retire), 32'd1);
      if (chk_lat) chk("latency", 32'(n), 32'(lat));
    end
    @(posedge clk);
    #1;
    check_arch();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    check_arch();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    iwait = 0;
    dwait = 0;
  endtask

  initial begin
    logic [31:0] w;
    int r, d, n;
    for (int i = 0; i < 65536; i++) begin
      dmem[i] = 16'd0;
      m_mem[i] = 16'd0;
    end
    for (int i = 0; i < 16384; i++) imem[i] = 32'd0;
    do_reset();
    issue(ei(OP_MOV, F_II, 4'd0, 4'd1, 16'd5), 0, 0, 0);
    issue(ei(OP_ADD, F_II, 4'd2, 4'd1, 16'hFFFA), 0, 0, 1);
    issue(ei(OP_ST, F_LDST, 4'd2, 4'd0, 16'd3), 0, 3, 1);
    chk("st_addr", 32'(last_addr), 32'd3);
    chk("st_wdata", 32'(last_wdata), 32'hFFFF);
    chk("st_we", 32'(last_we), 32'd1);
    issue(ei(OP_LD, F_LDST, 4'd3, 4'd0, 16'd3), 0, 3, 1);
    chk("ld_we", 32'(last_we), 32'd0);
    issue(ei(OP_MOV, F_II, 4'd0, 4'd4, 16'd0), 0, 0, 1);
    issue(ei(OP_BR, 3'b010, 4'd0, 4'd0, 16'hFFFE), 0, 0, 1);
    issue(ei(OP_BR, 3'b100, 4'd0, 4'd0, 16'hFFFE), 0, 0, 1);
    issue(ei(OP_BR, 3'b010, 4'd0, 4'd0, 16'd3), 1, 0, 1);
    issue(ei(OP_MOV, F_II, 4'd0, 4'd5, 16'h0040), 0, 0, 1);
    issue(ei(OP_JSR, 3'd0, 4'd0, 4'd0, 16'd4), 0, 0, 1);
    issue(ei(OP_JSRR, 3'd0, 4'd0, 4'd7, 16'd0), 0, 0, 1);
    issue(ei(OP_JMP, 3'd0, 4'd0, 4'd5, 16'd0), 2, 0, 1);
    lock = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("lock_imem_req", 32'(imem_req), 32'd0);
      chk("lock_pc", 32'(imem_addr), 32'(m_pc));
    end
    lock = 1'b1;
    issue(ei(OP_MOV, F_II, 4'd0, 4'd1, 16'h1234), 0, 0, 0);
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 4));
      d = int'($urandom_range(1, 15));
      case (r)
        0, 1: w = $urandom_range(0, 1) == 0 ?
                  er(r == 0 ? OP_ADD : OP_AND, 4'(d), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))) :
                  ei(r == 0 ? OP_ADD : OP_AND, F_II, 4'(d), 4'($urandom_range(0, 15)), 16'($urandom));
        2: w = $urandom_range(0, 1) == 0 ? er(OP_MOV, 4'd0, 4'(d), 4'($urandom_range(0, 15))) :
                                         ei(OP_MOV, F_II, 4'd0, 4'(d), 16'($urandom));
        3: w = ei(OP_LD, F_LDST, 4'(d), 4'd0, 16'($urandom_range(0, 15)));
        default: w = ei(OP_ST, F_LDST, 4'(d), 4'd0, 16'($urandom_range(0, 15)));
      endcase
      issue(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1);
    end
    issue(ei(5'h1F, 3'd0, 4'd1, 4'd1, 16'd0), 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("trap_imem_req", 32'(imem_req), 32'd0);
      chk("trap_dmem_req", 32'(dmem_req), 32'd0);
    end
    chk("trap_pc", 32'(pc), 32'(m_pc));
    do_reset();
    issue(ei(OP_MOV, F_II, 4'd0, 4'd1, 16'h1234), 0, 0, 0);
    imem[m_pc[15:2]] = ei(OP_ST, F_LDST, 4'd1, 4'd0, 16'd40);
    dwait = 20;
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req_seen", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_dmem_req", 32'(dmem_req), 32'd0);
    chk("async_imem_req", 32'(imem_req), 32'd0);
    check_arch();
    chk("store_abandoned", 32'(dmem[40]), 32'(m_mem[40]));
    @(negedge clk);
    rst_n = 1'b1;
    dwait = 0;
    issue(ei(OP_ADD, F_II, 4'd2, 4'd0, 16'd7), 0, 0, 0);
    issue(er(OP_ADD, 4'd3, 4'd2, 4'd2), 0, 0, 1);
    chk("handshake_stable", 32'(stab_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
